// File: rtl/switch_port_rx.sv
// switch_port_rx
//   Receive side of one switch input port. Each valid_ip strobe carries one
//   {data[15:8], source[7:4], target[3:0]} word. The word's packet type is
//   decoded and stored with it in a first-word-fall-through FIFO. suspend_ip
//   throttles the sender, and the FIFO head is offered to the fabric on a
//   valid/ready handshake.
//
// Ports
//   clk, reset          clock and synchronous active-high reset
//   valid_ip, data_ip   incoming word strobe and word
//   suspend_ip          registered back-pressure to the sender
//   pkt_valid/ready     FIFO head handshake with the fabric
//   pkt_data/source/target/type
//                       FIFO head fields; all zero while the FIFO is empty
//   bad_target          one-cycle pulse when a target-0 word is discarded
//   overflow            one-cycle pulse when a word is dropped on a full FIFO
//   proto_err           one-cycle pulse for a word sent while suspended or
//                       carrying the wrong source
//   drop_cnt            saturating count of discarded words
module switch_port_rx #(
    parameter int DEPTH       = 4,
    parameter int SUSP_MARGIN = 1,
    parameter int PORT_ID     = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_ip,
    input  logic [15:0] data_ip,
    output logic        suspend_ip,
    output logic        pkt_valid,
    input  logic        pkt_ready,
    output logic [7:0]  pkt_data,
    output logic [3:0]  pkt_source,
    output logic [3:0]  pkt_target,
    output logic [1:0]  pkt_type,
    output logic        bad_target,
    output logic        overflow,
    output logic        proto_err,
    output logic [7:0]  drop_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] SUSP_LVL = CW'(DEPTH - SUSP_MARGIN);
    localparam logic [3:0]    EXP_SRC  = 4'(1 << PORT_ID);

    // Each entry is {type, data, source, target}.
    logic [17:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          suspend_q, suspend_d;
    logic          bad_q, bad_d;
    logic          ovf_q, ovf_d;
    logic          proto_q, proto_d;
    logic [7:0]    drop_q, drop_d;

    logic          push, pop, push_req;
    logic [1:0]    in_type;
    logic [17:0]   head;

    function automatic logic [1:0] decode_type(input logic [3:0] t);
        if (t == 4'hF)
            return 2'b10;
        else if ($countones(t) == 1)
            return 2'b00;
        else
            return 2'b01;
    endfunction

    always_comb begin
        in_type   = decode_type(data_ip[3:0]);
        pop       = (count_q != '0) && pkt_ready;
        push_req  = valid_ip && (data_ip[3:0] != 4'h0);
        // A full FIFO still accepts a word when the head leaves in the same cycle.
        push      = push_req && ((count_q != FULL_LVL) || pop);
        bad_d     = valid_ip && (data_ip[3:0] == 4'h0);
        ovf_d     = push_req && !push;
        proto_d   = valid_ip && (suspend_q || (data_ip[7:4] != EXP_SRC));
        count_d   = count_q + CW'(push) - CW'(pop);
        suspend_d = (count_d >= SUSP_LVL);
        drop_d    = drop_q;
        if ((bad_d || ovf_d) && (drop_q != 8'hFF))
            drop_d = drop_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            suspend_q <= 1'b0;
            bad_q     <= 1'b0;
            ovf_q     <= 1'b0;
            proto_q   <= 1'b0;
            drop_q    <= 8'h00;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q   <= count_d;
            suspend_q <= suspend_d;
            bad_q     <= bad_d;
            ovf_q     <= ovf_d;
            proto_q   <= proto_d;
            drop_q    <= drop_d;
        end
    end

    // Storage needs no reset: the head is masked while count is zero.
    always_ff @(posedge clk) begin
        if (push && !reset)
            mem_q[wr_ptr_q] <= {in_type, data_ip};
    end

    always_comb begin
        head       = mem_q[rd_ptr_q];
        pkt_valid  = (count_q != '0);
        pkt_type   = pkt_valid ? head[17:16] : 2'b00;
        pkt_data   = pkt_valid ? head[15:8]  : 8'h00;
        pkt_source = pkt_valid ? head[7:4]   : 4'h0;
        pkt_target = pkt_valid ? head[3:0]   : 4'h0;
    end

    assign suspend_ip = suspend_q;
    assign bad_target = bad_q;
    assign overflow   = ovf_q;
    assign proto_err  = proto_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_switch_port_rx.sv
// Self-checking bench for switch_port_rx (DEPTH=4, SUSP_MARGIN=1, PORT_ID=0).
// A queue-based model of the port is compared against the DUT on every
// negative edge, and directed scenarios add literal expectations.
module tb_switch_port_rx;

    localparam int DEPTH       = 4;
    localparam int SUSP_MARGIN = 1;
    localparam int PORT_ID     = 0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_ip = 1'b0;
    logic [15:0] data_ip = 16'h0000;
    logic        pkt_ready = 1'b0;
    logic        suspend_ip, pkt_valid;
    logic [7:0]  pkt_data, drop_cnt;
    logic [3:0]  pkt_source, pkt_target;
    logic [1:0]  pkt_type;
    logic        bad_target, overflow, proto_err;

    int n_total = 0;
    int n_bad   = 0;

    switch_port_rx #(.DEPTH(DEPTH), .SUSP_MARGIN(SUSP_MARGIN), .PORT_ID(PORT_ID)) dut (
        .clk(clk), .reset(reset), .valid_ip(valid_ip), .data_ip(data_ip),
        .suspend_ip(suspend_ip), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .pkt_data(pkt_data), .pkt_source(pkt_source), .pkt_target(pkt_target),
        .pkt_type(pkt_type), .bad_target(bad_target), .overflow(overflow),
        .proto_err(proto_err), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [15:0] m_q[$];
    bit          m_susp  = 0;
    bit          m_bad   = 0;
    bit          m_ovf   = 0;
    bit          m_proto = 0;
    int          m_drop  = 0;

    function automatic int type_of(input logic [3:0] t);
        case (t)
            4'h1, 4'h2, 4'h4, 4'h8: return 0;
            4'hF:                   return 2;
            default:                return 1;
        endcase
    endfunction

    always @(posedge clk) begin
        bit do_pop;
        if (reset) begin
            m_q.delete();
            m_susp = 0; m_bad = 0; m_ovf = 0; m_proto = 0; m_drop = 0;
        end else begin
            do_pop  = (m_q.size() != 0) && pkt_ready;
            m_bad   = 0;
            m_ovf   = 0;
            m_proto = 0;
            if (do_pop)
                void'(m_q.pop_front());
            if (valid_ip) begin
                m_proto = m_susp || (data_ip[7:4] != 4'(1 << PORT_ID));
                if (data_ip[3:0] == 4'h0)
                    m_bad = 1;
                else if (m_q.size() < DEPTH)
                    m_q.push_back(data_ip);
                else
                    m_ovf = 1;
            end
            if ((m_bad || m_ovf) && m_drop < 255)
                m_drop++;
            m_susp = (m_q.size() >= DEPTH - SUSP_MARGIN);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("pkt_valid", int'(pkt_valid), int'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk("pkt_data",   int'(pkt_data),   int'(m_q[0][15:8]));
            chk("pkt_source", int'(pkt_source), int'(m_q[0][7:4]));
            chk("pkt_target", int'(pkt_target), int'(m_q[0][3:0]));
            chk("pkt_type",   int'(pkt_type),   type_of(m_q[0][3:0]));
        end else begin
            chk("pkt_fields_idle", int'({pkt_data, pkt_source, pkt_target, pkt_type}), 0);
        end
        chk("suspend_ip", int'(suspend_ip), int'(m_susp));
        chk("bad_target", int'(bad_target), int'(m_bad));
        chk("overflow",   int'(overflow),   int'(m_ovf));
        chk("proto_err",  int'(proto_err),  int'(m_proto));
        chk("drop_cnt",   int'(drop_cnt),   m_drop);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] w);
        valid_ip = 1'b1;
        data_ip  = w;
        tick();
        valid_ip = 1'b0;
    endtask

    task automatic pop_one();
        pkt_ready = 1'b1;
        tick();
        pkt_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // reset state
        tick(); tick();
        @(negedge clk);
        chk("rst_valid",   int'(pkt_valid), 0);
        chk("rst_suspend", int'(suspend_ip), 0);
        chk("rst_drop",    int'(drop_cnt), 0);
        reset = 1'b0;
        tick();

        // 1: single word, then pop
        send(16'hA512);
        @(negedge clk);
        chk("t1_valid",  int'(pkt_valid), 1);
        chk("t1_data",   int'(pkt_data), 'hA5);
        chk("t1_source", int'(pkt_source), 1);
        chk("t1_target", int'(pkt_target), 2);
        chk("t1_type",   int'(pkt_type), 0);
        pop_one();
        @(negedge clk);
        chk("t1_empty", int'(pkt_valid), 0);

        // 2: broadcast + multicast back to back, then a source mismatch
        send(16'h111F);
        send(16'h2216);
        send(16'h3321);
        @(negedge clk);
        chk("t2_proto_src", int'(proto_err), 1);
        chk("t2_type_bc",   int'(pkt_type), 2);
        chk("t2_data0",     int'(pkt_data), 'h11);
        pop_one();
        @(negedge clk);
        chk("t2_type_mc", int'(pkt_type), 1);
        chk("t2_data1",   int'(pkt_data), 'h22);
        pop_one();
        @(negedge clk);
        chk("t2_src_kept", int'(pkt_source), 2);
        pop_one();

        // 3: target 0 discarded
        send(16'h3310);
        @(negedge clk);
        chk("t3_bad",   int'(bad_target), 1);
        chk("t3_drop",  int'(drop_cnt), 1);
        chk("t3_valid", int'(pkt_valid), 0);
        tick();
        @(negedge clk);
        chk("t3_bad_pulse", int'(bad_target), 0);

        // 4: fill, suspend, overflow, suspend release
        do_reset();
        send(16'h4011);
        send(16'h4112);
        send(16'h4214);
        @(negedge clk);
        chk("t4_susp_on", int'(suspend_ip), 1);
        send(16'h4318);
        @(negedge clk);
        chk("t4_proto", int'(proto_err), 1);
        chk("t4_ovf0",  int'(overflow), 0);
        send(16'h4411);
        @(negedge clk);
        chk("t4_ovf",  int'(overflow), 1);
        chk("t4_drop", int'(drop_cnt), 1);
        pop_one();
        @(negedge clk);
        chk("t4_susp_hold", int'(suspend_ip), 1);
        pop_one();
        @(negedge clk);
        chk("t4_susp_off", int'(suspend_ip), 0);

        // 5: full FIFO push+pop in the same cycle
        do_reset();
        send(16'h5011);
        send(16'h5111);
        send(16'h5211);
        send(16'h5311);
        pkt_ready = 1'b1;
        send(16'h5412);
        pkt_ready = 1'b0;
        @(negedge clk);
        chk("t5_no_ovf", int'(overflow), 0);
        chk("t5_head",   int'(pkt_data), 'h51);
        chk("t5_susp",   int'(suspend_ip), 1);
        pkt_ready = 1'b1;
        repeat (4) tick();
        pkt_ready = 1'b0;
        @(negedge clk);
        chk("t5_drained", int'(pkt_valid), 0);

        // push+pop with a single entry: head advances to the new word
        send(16'h6011);
        pkt_ready = 1'b1;
        send(16'h6112);
        pkt_ready = 1'b0;
        @(negedge clk);
        chk("t5b_valid", int'(pkt_valid), 1);
        chk("t5b_head",  int'(pkt_data), 'h61);
        pop_one();

        // 6: drop counter saturation, then reset mid-stream
        do_reset();
        send(16'h7011);
        send(16'h7112);
        valid_ip = 1'b1;
        data_ip  = 16'h0010;
        repeat (300) tick();
        @(negedge clk);
        chk("t6_sat", int'(drop_cnt), 'hFF);
        data_ip = 16'h8011;
        reset   = 1'b1;
        tick();
        @(negedge clk);
        chk("t6_rst_valid", int'(pkt_valid), 0);
        chk("t6_rst_drop",  int'(drop_cnt), 0);
        chk("t6_rst_data",  int'(pkt_data), 0);
        chk("t6_rst_bad",   int'(bad_target), 0);
        reset    = 1'b0;
        valid_ip = 1'b0;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
